// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: HI/LO registers, multi-cycle mult/div with busy handshake.
// MULT_CYCLES/DIV_CYCLES busy cycles per op; `define MDU_MADD_EN enables madd/maddu (codes 9/10).
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic [3:0]  mdOp,
    output logic        start,
    output logic        busy,
    output logic [31:0] mdResult
);
`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;

    localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic [3:0]    op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    logic          is_mul, is_div, is_madd, launch;
    logic          op_signed, a_neg, b_neg;
    logic [63:0]   ax, bx, prod;
    logic [31:0]   mag_a, mag_b, den, uq, ur, quo, rem;
    logic [31:0]   hi_c, lo_c;

    always_comb begin
        is_mul  = (mdOp == OP_MULT) || (mdOp == OP_MULTU);
        is_div  = (mdOp == OP_DIV)  || (mdOp == OP_DIVU);
        is_madd = MADD_EN && ((mdOp == OP_MADD) || (mdOp == OP_MADDU));
        start   = is_mul || is_div || is_madd;
        launch  = start && !busy_q;
    end

    // Signed division is done on magnitudes so 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        op_signed = (op_q == OP_MULT) || (op_q == OP_DIV) || (op_q == OP_MADD);
        ax    = op_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        bx    = op_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod  = ax * bx;
        a_neg = op_signed & a_q[31];
        b_neg = op_signed & b_q[31];
        mag_a = a_neg ? (~a_q + 32'd1) : a_q;
        mag_b = b_neg ? (~b_q + 32'd1) : b_q;
        den   = (b_q == 32'd0) ? 32'd1 : mag_b;
        uq    = mag_a / den;
        ur    = mag_a % den;
        quo   = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
        rem   = a_neg ? (~ur + 32'd1) : ur;
    end

    always_comb begin
        hi_c = hi_q;
        lo_c = lo_q;
        case (op_q)
            OP_MULT, OP_MULTU: {hi_c, lo_c} = prod;
            OP_DIV, OP_DIVU: begin
                if (b_q != 32'd0) begin
                    hi_c = rem;
                    lo_c = quo;
                end
            end
            // HI/LO cannot change while busy, so the live value is the launch-time accumulator.
            OP_MADD, OP_MADDU: {hi_c, lo_c} = {hi_q, lo_q} + prod;
            default: ;
        endcase
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (busy_q) begin
            if (cnt_q == CW'(1)) begin
                hi_d   = hi_c;
                lo_d   = lo_c;
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end else if (launch) begin
            a_d    = srcA;
            b_d    = srcB;
            op_d   = mdOp;
            busy_d = 1'b1;
            cnt_d  = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (mdOp == OP_MTHI) begin
            hi_d = srcA;
        end else if (mdOp == OP_MTLO) begin
            lo_d = srcA;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

    always_comb begin
        case (mdOp)
            OP_MFHI: mdResult = hi_q;
            OP_MFLO: mdResult = lo_q;
            default: mdResult = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: vector table, hand-written corner sequences, randomized ops against a HI/LO model.
module tb_e_mdu;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] srcA = '0, srcB = '0;
    logic [3:0]  mdOp = '0;
    logic        start, busy;
    logic [31:0] mdResult;

    int total = 0;
    int bad   = 0;
    logic [31:0] hi_m = '0, lo_m = '0;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .srcA(srcA), .srcB(srcB), .mdOp(mdOp),
        .start(start), .busy(busy), .mdResult(mdResult)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;
    vec_t tbl[9];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int cycles_of(input logic [3:0] op);
        return (op == 4'd3 || op == 4'd4) ? DC : MC;
    endfunction

    // Reference: plain 64-bit integer arithmetic on the architectural HI/LO.
    task automatic model_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p, acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd1: begin p = 64'(sa * sb); {hi_m, lo_m} = p; end
            4'd2: begin p = {32'd0, a} * {32'd0, b}; {hi_m, lo_m} = p; end
            4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0]; end
            4'd4: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
            4'd9: begin p = 64'(sa * sb); acc = {hi_m, lo_m} + p; {hi_m, lo_m} = acc; end
            4'd10: begin p = {32'd0, a} * {32'd0, b}; acc = {hi_m, lo_m} + p; {hi_m, lo_m} = acc; end
            default: ;
        endcase
    endtask

    task automatic read_hilo(input string tag);
        mdOp = 4'd5; #1; check({tag, "_mfhi"}, mdResult, hi_m);
        mdOp = 4'd6; #1; check({tag, "_mflo"}, mdResult, lo_m);
        mdOp = 4'd0; #1;
    endtask

    task automatic do_mt(input logic [3:0] op, input logic [31:0] v);
        mdOp = op; srcA = v; #1;
        check("mt_start", {31'd0, start}, 32'd0);
        tick();
        check("mt_busy", {31'd0, busy}, 32'd0);
        if (op == 4'd7) hi_m = v; else lo_m = v;
        mdOp = 4'd0;
    endtask

    // Launches in the current cycle; returns in the first cycle after busy falls.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit noisy);
        logic [31:0] prior_lo;
        int n;
        logic [3:0] noise_ops[6];
        noise_ops = '{4'd0, 4'd1, 4'd3, 4'd7, 4'd8, 4'd5};
        prior_lo = lo_m;
        mdOp = op; srcA = a; srcB = b; #1;
        check({tag, "_start"}, {31'd0, start}, 32'd1);
        tick();
        model_exec(op, a, b);
        mdOp = 4'd6; #1;
        check({tag, "_prior_lo"}, mdResult, prior_lo);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (noisy) begin
                srcA = $urandom; srcB = $urandom;
                mdOp = noise_ops[$urandom_range(0, 5)];
            end
            tick();
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'(cycles_of(op)));
        read_hilo(tag);
    endtask

    initial begin
        tbl[0] = '{4'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE};
        tbl[1] = '{4'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
        tbl[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3] = '{4'd4, 32'd7,        32'd2,        32'd1,        32'd3};
        tbl[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
        tbl[5] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tbl[6] = '{4'd4, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF};
        tbl[7] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        tbl[8] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};

        reset = 1'b1;
        tick(); tick();
        reset = 1'b0; #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_nope_result", mdResult, 32'd0);
        read_hilo("rst");

        for (int c = 5; c < 16; c++) begin
            mdOp = 4'(c); #1;
`ifdef MDU_MADD_EN
            check("start_decode", {31'd0, start}, (c == 9 || c == 10) ? 32'd1 : 32'd0);
`else
            check("start_decode", {31'd0, start}, 32'd0);
`endif
        end
        mdOp = 4'd0; #1;

        // Back-to-back: each run_op launches in the cycle right after the previous busy fell.
        for (int i = 0; i < 9; i++) begin
            run_op("tbl", tbl[i].op, tbl[i].a, tbl[i].b, 1'b0);
            mdOp = 4'd5; #1; check("tbl_hi_const", mdResult, tbl[i].hi);
            mdOp = 4'd6; #1; check("tbl_lo_const", mdResult, tbl[i].lo);
            mdOp = 4'd0; #1;
        end

        // Divide by zero leaves HI/LO untouched.
        do_mt(4'd7, 32'h1234);
        do_mt(4'd8, 32'h5678);
        run_op("div0", 4'd3, 32'd99, 32'd0, 1'b0);
        mdOp = 4'd5; #1; check("div0_hi_const", mdResult, 32'h1234);
        mdOp = 4'd6; #1; check("div0_lo_const", mdResult, 32'h5678);
        mdOp = 4'd0; #1;

        // mtlo while busy is ignored.
        mdOp = 4'd1; srcA = 32'd3; srcB = 32'd4; #1;
        tick();
        mdOp = 4'd8; srcA = 32'hAAAA; tick();
        mdOp = 4'd7; srcA = 32'hBBBB; tick();
        mdOp = 4'd0;
        for (int k = 0; k < 20 && busy === 1'b1; k++) tick();
        hi_m = 32'd0; lo_m = 32'd12;
        read_hilo("mt_busy");

        // Reset in busy cycle 3 of a div aborts it with no late commit.
        mdOp = 4'd4; srcA = 32'd100; srcB = 32'd7; #1;
        tick();
        mdOp = 4'd0;
        tick(); tick();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1; tick(); reset = 1'b0; #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        hi_m = 32'd0; lo_m = 32'd0;
        read_hilo("midrst");
        for (int k = 0; k < DC + 2; k++) tick();
        check("midrst_late_busy", {31'd0, busy}, 32'd0);
        read_hilo("midrst_late");

`ifdef MDU_MADD_EN
        do_mt(4'd7, 32'd0);
        do_mt(4'd8, 32'hFFFFFFFF);
        run_op("maddu", 4'd10, 32'd1, 32'd1, 1'b0);
        mdOp = 4'd5; #1; check("maddu_hi_const", mdResult, 32'd1);
        mdOp = 4'd6; #1; check("maddu_lo_const", mdResult, 32'd0);
        mdOp = 4'd0; #1;
`else
        do_mt(4'd7, 32'd0);
        do_mt(4'd8, 32'hFFFFFFFF);
        mdOp = 4'd10; srcA = 32'd1; srcB = 32'd1; #1;
        check("maddu_off_start", {31'd0, start}, 32'd0);
        check("maddu_off_result", mdResult, 32'd0);
        tick();
        mdOp = 4'd9; #1;
        check("madd_off_start", {31'd0, start}, 32'd0);
        tick();
        check("maddu_off_busy", {31'd0, busy}, 32'd0);
        read_hilo("maddu_off");
`endif

        // Randomized ops, with operand/op noise during busy to exercise latching and ignore rules.
        for (int it = 0; it < 40; it++) begin
            logic [3:0] op;
            logic [31:0] a, b;
            int sel;
`ifdef MDU_MADD_EN
            sel = $urandom_range(0, 7);
`else
            sel = $urandom_range(0, 5);
`endif
            case (sel)
                0: op = 4'd1; 1: op = 4'd2; 2: op = 4'd3; 3: op = 4'd4;
                4: op = 4'd7; 5: op = 4'd8; 6: op = 4'd9; default: op = 4'd10;
            endcase
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if (op == 4'd7 || op == 4'd8) begin
                do_mt(op, a);
                read_hilo("rnd_mt");
            end else begin
                run_op("rnd", op, a, b, 1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
